// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: job geometry, derived counts and scheduler state encoding
package conv_sched_pkg;
  localparam int IMG_W   = 6;
  localparam int IMG_H   = 6;
  localparam int K       = 3;
  localparam int STRIDE  = 1;
  localparam int NUM_F   = 2;
  localparam int TIMEOUT = 4096;
  localparam int OH      = (IMG_H - K) / STRIDE + 1;
  localparam int OW      = (IMG_W - K) / STRIDE + 1;
  localparam int N_OUT   = NUM_F * OH * OW;
  localparam int N_IMG   = IMG_W * IMG_H;
  localparam int N_FLT   = K * K;
  function automatic int cw(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  localparam int EW = cw(N_IMG);
  localparam int TW = cw(TIMEOUT);
  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_F0, LOAD_F1, LOAD_IMG, START, RUN, REPORT
  } state_e;
endpackage

// File: rtl/sched_load_counter.sv
// sched_load_counter: modulo counter wrapping after last_i, with terminal-count flag
module sched_load_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == last_i;
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: sequences filter/image loads, start and result checking for one conv job
module conv_job_scheduler
  import conv_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  input  logic [1:0]  job_reload_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic        abort_i,
  output logic        rst_data_o,
  output logic        lf_0_o,
  output logic        lf_1_o,
  output logic        ld_o,
  output logic        go_o,
  input  logic        out_valid_i,
  input  logic        conv_done_i,
  output logic        job_done_o,
  output logic        job_err_o,
  output logic [15:0] out_count_o,
  output logic        busy_o
);
  state_e state_q, state_d;
  logic [1:0] eff_q, eff_d, flt_q, flt_d;
  logic err_q, err_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic loading, el_tc, ld_done, to_tc;
  assign loading = state_q inside {LOAD_F0, LOAD_F1, LOAD_IMG};
  assign ld_done = loading && s_valid_i && el_tc;
  assign cnt_inc = (out_valid_i && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  sched_load_counter #(.W(EW)) u_elem (
    .clk, .rst_n,
    .clr_i (!loading),
    .en_i  (loading && s_valid_i),
    .last_i(state_q == LOAD_IMG ? EW'(N_IMG - 1) : EW'(N_FLT - 1)),
    .tc_o  (el_tc)
  );
  // runs from the go cycle so the timeout lands TIMEOUT cycles after go
  sched_load_counter #(.W(TW)) u_tmo (
    .clk, .rst_n,
    .clr_i (!(state_q inside {START, RUN})),
    .en_i  (1'b1),
    .last_i(TW'(TIMEOUT - 1)),
    .tc_o  (to_tc)
  );
  always_comb begin
    state_d = state_q;
    eff_d   = eff_q;
    flt_d   = flt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (job_valid_i) begin
        eff_d   = job_reload_i | ~flt_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = CLEAR;
      end
      CLEAR: state_d = eff_q[0] ? LOAD_F0 : eff_q[1] ? LOAD_F1 : LOAD_IMG;
      LOAD_F0: if (ld_done) begin
        flt_d[0] = 1'b1;
        state_d  = eff_q[1] ? LOAD_F1 : LOAD_IMG;
      end
      LOAD_F1: if (ld_done) begin
        flt_d[1] = 1'b1;
        state_d  = LOAD_IMG;
      end
      LOAD_IMG: if (ld_done) state_d = START;
      START: state_d = RUN;
      RUN: begin
        cnt_d = cnt_inc;
        if (conv_done_i) begin
          err_d   = cnt_inc != 16'(N_OUT);
          state_d = REPORT;
        end else if (to_tc) begin
          err_d   = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a half-written filter must be force-reloaded by the next job
    if (abort_i && state_q != IDLE && state_q != REPORT) begin
      err_d   = 1'b1;
      state_d = REPORT;
      if (state_q == LOAD_F0) flt_d[0] = 1'b0;
      if (state_q == LOAD_F1) flt_d[1] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      eff_q   <= '0;
      flt_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      eff_q   <= eff_d;
      flt_q   <= flt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  assign job_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign s_ready_o   = loading;
  assign rst_data_o  = state_q == CLEAR;
  assign lf_0_o      = state_q == LOAD_F0 && s_valid_i;
  assign lf_1_o      = state_q == LOAD_F1 && s_valid_i;
  assign ld_o        = state_q == LOAD_IMG && s_valid_i;
  assign go_o        = state_q == START;
  assign job_done_o  = state_q == REPORT;
  assign job_err_o   = state_q == REPORT && err_q;
  assign out_count_o = cnt_q;
endmodule
